// File: rtl/dma_in_sched.sv
// rtl/dma_in_sched.sv - descriptor FIFO and issue scheduler in front of a dma_in engine
// Optional ring mode (loop_en port) is enabled by defining DMA_IN_SCHED_LOOP_EN.
module dma_in_sched #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             desc_valid,
   output logic             desc_ready,
   input  logic [31:0]      desc_start_addr,
   input  logic [31:0]      desc_length,
   input  logic [31:0]      desc_timer_init,
   input  logic             desc_reverse,
   input  logic             desc_run_till_last,
   input  logic             flush,
`ifdef DMA_IN_SCHED_LOOP_EN
   input  logic             loop_en,
`endif
   output logic             config_valid,
   input  logic             config_ready,
   output logic [31:0]      config_payload_startAddr,
   output logic [31:0]      config_payload_length,
   output logic [31:0]      config_payload_timerInit,
   output logic             config_payload_reverse,
   output logic             config_payload_run_till_last,
   output logic             dma_reset,
   output logic [CNT_W-1:0] done_cnt,
   output logic [3:0]       pending,
   output logic             busy,
   output logic             interrupt,
   input  logic             interrupt_clear
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_FREE = CW'(DEPTH - 1);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] len;
      logic [31:0] timer;
      logic        rev;
      logic        rtl;
   } desc_t;

   typedef enum logic [1:0] {IDLE, ISSUE, ABORT} state_t;

   state_t          state, state_nx;
   desc_t           mem [DEPTH];
   desc_t           cur, in_desc;
   logic [AW-1:0]   wr_ptr, rd_ptr, wr_next;
   logic [CW-1:0]   count;
   logic [4:0]      count5;
   logic [CNT_W-1:0] done_q;
   logic            intr_q;
   logic            loop_on, issue_done, repush, push, pop, bypass, fifo_wr, intr_set;

`ifdef DMA_IN_SCHED_LOOP_EN
   assign loop_on = loop_en;
`else
   assign loop_on = 1'b0;
`endif

   assign in_desc    = {desc_start_addr, desc_length, desc_timer_init, desc_reverse, desc_run_till_last};
   assign issue_done = (state == ISSUE) && config_ready;
   assign repush     = issue_done && loop_on && !flush && (count != FULL);
   // The ring re-push claims the last free slot ahead of any external push.
   assign desc_ready = (count != FULL) && !(repush && (count == ONE_FREE));
   assign push       = desc_valid && desc_ready && !flush;
   assign pop        = (state == IDLE) && (count != '0) && !flush;
   assign bypass     = (state == IDLE) && (count == '0) && push;
   assign fifo_wr    = push && !bypass;
   assign wr_next    = wr_ptr + AW'(1);
   assign intr_set   = issue_done && (count == '0) && !push && !loop_on;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (pop || bypass) state_nx = ISSUE;
         ISSUE:   if (config_ready) state_nx = IDLE;
                  else if (flush) state_nx = ABORT;
         ABORT:   if (config_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) state <= IDLE;
      else      state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (repush)  mem[wr_ptr] <= cur;
      if (fifo_wr) mem[repush ? wr_next : wr_ptr] <= in_desc;
   end

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(fifo_wr) + AW'(repush);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(fifo_wr) + CW'(repush) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         cur    <= '0;
         done_q <= '0;
         intr_q <= 1'b0;
      end else begin
         if (pop)         cur <= mem[rd_ptr];
         else if (bypass) cur <= in_desc;
         if (issue_done)  done_q <= done_q + CNT_W'(1);
         if (intr_set)    intr_q <= 1'b1;
         else if (interrupt_clear) intr_q <= 1'b0;
      end
   end

   // Occupancy 16 (DEPTH=16) does not fit the 4-bit port; report it saturated.
   assign count5  = 5'(count);
   assign pending = count5[4] ? 4'hF : count5[3:0];

   assign config_valid                 = (state != IDLE);
   assign busy                         = (state != IDLE);
   assign dma_reset                    = (state == ABORT);
   assign config_payload_startAddr     = cur.addr;
   assign config_payload_length        = cur.len;
   assign config_payload_timerInit     = cur.timer;
   assign config_payload_reverse       = cur.rev;
   assign config_payload_run_till_last = cur.rtl;
   assign done_cnt                     = done_q;
   assign interrupt                    = intr_q;

endmodule

// File: tb/tb_dma_in_sched.sv
// tb/tb_dma_in_sched.sv - randomized bench for dma_in_sched against a queue-based reference model
// Define DMA_IN_SCHED_LOOP_EN to also exercise ring mode.
module tb_dma_in_sched;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] l;
      logic [31:0] t;
      logic        r;
      logic        d;
   } desc_t;

   logic clk = 1'b0;
   logic srst = 1'b1;
   logic desc_valid = 1'b0, desc_reverse = 1'b0, desc_run_till_last = 1'b0;
   logic [31:0] desc_start_addr = '0, desc_length = '0, desc_timer_init = '0;
   logic flush = 1'b0, config_ready = 1'b0, interrupt_clear = 1'b0, loop_en = 1'b0;
   logic desc_ready, config_valid, config_payload_reverse, config_payload_run_till_last;
   logic [31:0] config_payload_startAddr, config_payload_length, config_payload_timerInit;
   logic dma_reset, busy, interrupt;
   logic [CNT_W-1:0] done_cnt;
   logic [3:0] pending;

   dma_in_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .srst(srst),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_start_addr(desc_start_addr), .desc_length(desc_length),
      .desc_timer_init(desc_timer_init), .desc_reverse(desc_reverse),
      .desc_run_till_last(desc_run_till_last), .flush(flush),
`ifdef DMA_IN_SCHED_LOOP_EN
      .loop_en(loop_en),
`endif
      .config_valid(config_valid), .config_ready(config_ready),
      .config_payload_startAddr(config_payload_startAddr),
      .config_payload_length(config_payload_length),
      .config_payload_timerInit(config_payload_timerInit),
      .config_payload_reverse(config_payload_reverse),
      .config_payload_run_till_last(config_payload_run_till_last),
      .dma_reset(dma_reset), .done_cnt(done_cnt), .pending(pending),
      .busy(busy), .interrupt(interrupt), .interrupt_clear(interrupt_clear)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: a plain queue of waiting descriptors plus the one on offer.
   desc_t q[$];
   desc_t cur = '0;
   bit active = 0, aborting = 0, intr_m = 0;
   logic [CNT_W-1:0] done_m = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit loop_mode();
`ifdef DMA_IN_SCHED_LOOP_EN
      return loop_en;
`else
      return 1'b0;
`endif
   endfunction

   task automatic cycle();
      desc_t in_d;
      int sz;
      bit rep, rdy, psh, set_i;
      #1;
      in_d = {desc_start_addr, desc_length, desc_timer_init, desc_reverse, desc_run_till_last};
      sz   = q.size();
      rep  = loop_mode() && active && !aborting && config_ready && !flush && sz < DEPTH;
      rdy  = rep ? (sz < DEPTH - 1) : (sz < DEPTH);
      check("desc_ready", 64'(desc_ready), 64'(rdy));
      psh  = desc_valid && rdy && !flush;
      if (srst) begin
         q.delete();
         cur = '0; active = 0; aborting = 0; done_m = '0; intr_m = 0;
      end else begin
         set_i = active && !aborting && config_ready && sz == 0 && !psh && !loop_mode();
         if (!active) begin
            if (!flush && sz > 0) begin
               cur = q.pop_front(); active = 1;
            end else if (psh) begin
               cur = in_d; active = 1; psh = 0;
            end
         end else if (!aborting) begin
            if (config_ready) begin
               done_m++; active = 0;
               if (rep) q.push_back(cur);
            end else if (flush) aborting = 1;
         end else if (config_ready) begin
            active = 0; aborting = 0;
         end
         if (flush) q.delete();
         if (psh) q.push_back(in_d);
         if (set_i) intr_m = 1;
         else if (interrupt_clear) intr_m = 0;
      end
      @(posedge clk);
      #1;
      check("config_valid", 64'(config_valid), 64'(active));
      check("busy", 64'(busy), 64'(active));
      check("dma_reset", 64'(dma_reset), 64'(aborting));
      check("payload", {config_payload_startAddr, config_payload_length},
            {cur.a, cur.l});
      check("payload_misc", {config_payload_timerInit, config_payload_reverse,
            config_payload_run_till_last}, {cur.t, cur.r, cur.d});
      check("done_cnt", 64'(done_cnt), 64'(done_m));
      check("pending", 64'(pending), 64'(q.size()));
      check("interrupt", 64'(interrupt), 64'(intr_m));
   endtask

   task automatic quiet();
      desc_valid = 0; flush = 0; config_ready = 0; interrupt_clear = 0; srst = 0;
   endtask

   task automatic set_desc(input logic [31:0] a, input logic [31:0] l);
      desc_start_addr = a; desc_length = l;
      desc_timer_init = $urandom; desc_reverse = 1'($urandom); desc_run_till_last = 1'($urandom);
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] l);
      quiet(); set_desc(a, l); desc_valid = 1; cycle(); quiet();
   endtask

   task automatic idle(input int n);
      quiet();
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic ack();
      quiet(); config_ready = 1; cycle(); quiet();
   endtask

   initial begin
      // Reset
      srst = 1; cycle(); cycle();
      quiet(); cycle();
      check("rst_valid", 64'(config_valid), 64'd0);
      check("rst_ready", 64'(desc_ready), 64'd1);
      check("rst_done", 64'(done_cnt), 64'd0);

      // Single descriptor, acked 8 cycles after config_valid rises
      push(32'h100, 32'd8);
      check("t1_valid", 64'(config_valid), 64'd1);
      check("t1_addr", 64'(config_payload_startAddr), 64'h100);
      check("t1_len", 64'(config_payload_length), 64'd8);
      idle(8);
      ack();
      check("t1_done", 64'(done_cnt), 64'd1);
      check("t1_intr", 64'(interrupt), 64'd1);

      // Overfill while the engine stalls, then drain back to back
      for (int i = 0; i < 6; i++) push(32'h200 + 32'(i), 32'(i));
      check("t2_full", 64'(desc_ready), 64'd0);
      check("t2_pending", 64'(pending), 64'd4);
      for (int i = 0; i < 5; i++) begin
         ack();
         check("t2_bubble", 64'(config_valid), 64'd0);
         idle(1);
      end
      idle(2);
      check("t2_done", 64'(done_cnt), 64'd6);

      // Flush mid-issue with two queued
      interrupt_clear = 1; cycle(); quiet();
      for (int i = 0; i < 3; i++) push(32'h300 + 32'(i), 32'd4);
      flush = 1; cycle(); quiet();
      check("t3_pending", 64'(pending), 64'd0);
      check("t3_dmarst", 64'(dma_reset), 64'd1);
      idle(3);
      ack();
      check("t3_dmarst_end", 64'(dma_reset), 64'd0);
      check("t3_done", 64'(done_cnt), 64'd6);
      check("t3_intr", 64'(interrupt), 64'd0);

      // Clear coinciding with a drain completion: set wins; zero-length descriptor
      push(32'h400, 32'd0);
      idle(1);
      config_ready = 1; interrupt_clear = 1; cycle(); quiet();
      check("t4_setwins", 64'(interrupt), 64'd1);
      interrupt_clear = 1; cycle(); quiet();
      check("t4_clear", 64'(interrupt), 64'd0);

`ifdef DMA_IN_SCHED_LOOP_EN
      begin
         logic [31:0] seen [6];
         logic [31:0] base;
         int guard;
         base = 32'(done_cnt);
         loop_en = 1;
         push(32'hA, 32'd1);
         push(32'hB, 32'd2);
         for (int i = 0; i < 6; i++) begin
            guard = 0;
            while (!config_valid && guard < 8) begin idle(1); guard++; end
            check("t5_wait", 64'(config_valid), 64'd1);
            seen[i] = config_payload_startAddr;
            ack();
         end
         for (int i = 0; i < 6; i++) check("t5_order", 64'(seen[i]), (i % 2 == 0) ? 64'hA : 64'hB);
         check("t5_done", 64'(done_cnt), 64'(4'(base + 6)));
         check("t5_intr", 64'(interrupt), 64'd0);
         idle(2);
         flush = 1; cycle(); quiet();
         idle(1); ack(); idle(2);
         loop_en = 0;
      end
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
`ifdef DMA_IN_SCHED_LOOP_EN
         if (n % 250 == 0) loop_en = ($urandom_range(0, 3) == 0);
`endif
         set_desc($urandom, $urandom_range(0, 64));
         desc_valid      = ($urandom_range(0, 1) == 1);
         config_ready    = ($urandom_range(0, 9) < 4);
         flush           = ($urandom_range(0, 39) == 0);
         interrupt_clear = ($urandom_range(0, 9) == 0);
         srst            = ($urandom_range(0, 499) == 0);
         cycle();
      end
      quiet(); loop_en = 0; cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
